// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/phase encodings and helpers for the 8-bit RISC CPU.
// Imported by cpu_controller; no ports.
package cpu_pkg;

   localparam int CPU_OPCODE_W = 3;
   localparam int CPU_PHASE_W  = 3;

   localparam logic [CPU_OPCODE_W-1:0] OP_HLT = 3'd0;
   localparam logic [CPU_OPCODE_W-1:0] OP_SKZ = 3'd1;
   localparam logic [CPU_OPCODE_W-1:0] OP_ADD = 3'd2;
   localparam logic [CPU_OPCODE_W-1:0] OP_AND = 3'd3;
   localparam logic [CPU_OPCODE_W-1:0] OP_XOR = 3'd4;
   localparam logic [CPU_OPCODE_W-1:0] OP_LDA = 3'd5;
   localparam logic [CPU_OPCODE_W-1:0] OP_STO = 3'd6;
   localparam logic [CPU_OPCODE_W-1:0] OP_JMP = 3'd7;

   typedef enum logic [CPU_PHASE_W-1:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic wr;
      logic ld_ir;
      logic ld_ac;
      logic ld_pc;
      logic inc_pc;
      logic data_e;
      logic halt;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic is_aluop(
      input logic [CPU_OPCODE_W-1:0] op
   );
      return (op == OP_ADD) || (op == OP_AND) ||
             (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer producing memory, mux,
// register-load and halt strobes from phase, opcode and zero.
// Ports: clk, rst_n (async, active-low), opcode, zero ->
//   sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase.
// Optional macro CPU_CTRL_SINGLE_STEP_EN adds input step: phase 0 holds
// until step is sampled high, then one full instruction runs.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = CPU_OPCODE_W,
   parameter int PHASE_W  = CPU_PHASE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
`ifdef CPU_CTRL_SINGLE_STEP_EN
   input  logic                step,
`endif
   output logic                sel,
   output logic                rd,
   output logic                wr,
   output logic                ld_ir,
   output logic                ld_ac,
   output logic                ld_pc,
   output logic                inc_pc,
   output logic                data_e,
   output logic                halt,
   output logic [PHASE_W-1:0]  phase
);

   phase_e r_phase;
   logic   r_halted;

   phase_e w_phase_nxt;
   logic   w_halted_nxt;
   logic   w_run;
   logic   w_alu;
   logic   w_is_hlt;
   logic   w_is_skz;
   logic   w_is_sto;
   logic   w_is_jmp;
   ctrl_t  w_ctrl;

   assign w_alu    = is_aluop(opcode);
   assign w_is_hlt = (opcode == OP_HLT);
   assign w_is_skz = (opcode == OP_SKZ);
   assign w_is_sto = (opcode == OP_STO);
   assign w_is_jmp = (opcode == OP_JMP);

   // Single-step gate only matters at the instruction boundary.
`ifdef CPU_CTRL_SINGLE_STEP_EN
   assign w_run = (r_phase != PH_INST_ADDR) || step;
`else
   assign w_run = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= PH_INST_ADDR;
         r_halted <= 1'b0;
      end else begin
         r_phase  <= w_phase_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   // Next state: HLT in OP_ADDR freezes the phase at 4 and latches halt.
   always_comb begin
      w_phase_nxt  = r_phase;
      w_halted_nxt = r_halted;
      if (!r_halted) begin
         if ((r_phase == PH_OP_ADDR) && w_is_hlt) begin
            w_halted_nxt = 1'b1;
         end else if (w_run) begin
            w_phase_nxt = phase_e'(r_phase + 3'd1);
         end
      end
   end

   // Output decode.
   always_comb begin
      w_ctrl = CTRL_IDLE;
      unique case (r_phase)
         PH_INST_ADDR: begin
            w_ctrl.sel = 1'b1;
         end
         PH_INST_FETCH: begin
            w_ctrl.sel = 1'b1;
            w_ctrl.rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            w_ctrl.sel   = 1'b1;
            w_ctrl.rd    = 1'b1;
            w_ctrl.ld_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            w_ctrl.inc_pc = 1'b1;
            w_ctrl.halt   = w_is_hlt;
         end
         PH_OP_FETCH: begin
            w_ctrl.rd = w_alu;
         end
         PH_ALU_OP: begin
            w_ctrl.rd     = w_alu;
            w_ctrl.inc_pc = w_is_skz && zero;
            w_ctrl.ld_pc  = w_is_jmp;
            w_ctrl.data_e = w_is_sto;
         end
         PH_STORE: begin
            w_ctrl.rd     = w_alu;
            w_ctrl.ld_ac  = w_alu;
            w_ctrl.inc_pc = w_is_jmp;
            w_ctrl.ld_pc  = w_is_jmp;
            w_ctrl.wr     = w_is_sto;
            w_ctrl.data_e = w_is_sto;
         end
         default: begin
            w_ctrl = CTRL_IDLE;
         end
      endcase
      // Once halted every strobe is dead except halt itself.
      if (r_halted) begin
         w_ctrl      = CTRL_IDLE;
         w_ctrl.halt = 1'b1;
      end
   end

   assign sel    = w_ctrl.sel;
   assign rd     = w_ctrl.rd;
   assign wr     = w_ctrl.wr;
   assign ld_ir  = w_ctrl.ld_ir;
   assign ld_ac  = w_ctrl.ld_ac;
   assign ld_pc  = w_ctrl.ld_pc;
   assign inc_pc = w_ctrl.inc_pc;
   assign data_e = w_ctrl.data_e;
   assign halt   = w_ctrl.halt;
   assign phase  = PHASE_W'(r_phase);

endmodule
